bcd_step_counter: RTL and testbench

Consumes the debounced push-button levels and maintains an NDIG-digit packed-BCD up/down count for the downstream seven-segment display multiplexer. Each clean rising edge on `inc_deb`/`dec_deb` steps the count by one with decimal carry/borrow and wrap-around; `clr_deb` forces zero. An optional hold-to-repeat feature steps continuously while a button stays pressed.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_step_counter_if.sv | 27 ++
 rtl/bcd_digit_updown.sv | 40 ++++
 rtl/bcd_step_counter.sv | 161 ++++++++++++++++
 tb/tb_bcd_step_counter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared digit type, BCD limits and auto-repeat state encoding
// for the BCD step counter.
`default_nettype none

package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_step_counter_if.sv
// bcd_step_counter_if: button levels in, packed BCD count and event pulses out.
`default_nettype none

interface bcd_step_counter_if #(
  parameter int NDIG = 4
);

  logic              inc_deb;
  logic              dec_deb;
  logic              clr_deb;
  logic [4*NDIG-1:0] bcd;
  logic              step;
  logic              wrap;

  modport master (
    output inc_deb, dec_deb, clr_deb,
    input  bcd, step, wrap
  );

  modport slave (
    input  inc_deb, dec_deb, clr_deb,
    output bcd, step, wrap
  );

endinterface

`default_nettype wire

// File: rtl/bcd_digit_updown.sv
// bcd_digit_updown: one combinational BCD digit stage with carry/borrow
// propagation; digits never leave the 0..9 range.
`default_nettype none

module bcd_digit_updown
  import bcd_pkg::*;
(
  input  wire bcd_digit_t i_digit,
  input  wire             i_up,
  input  wire             i_dn,
  input  wire             i_cin,
  output bcd_digit_t      o_digit,
  output logic            o_cout
);

  always_comb begin
    o_digit = i_digit;
    o_cout  = 1'b0;
    if (i_cin) begin
      if (i_up) begin
        if (i_digit == BCD_MAX) begin
          o_digit = BCD_MIN;
          o_cout  = 1'b1;
        end else begin
          o_digit = i_digit + 4'd1;
        end
      end else if (i_dn) begin
        if (i_digit == BCD_MIN) begin
          o_digit = BCD_MAX;
          o_cout  = 1'b1;
        end else begin
          o_digit = i_digit - 4'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_step_counter.sv
// bcd_step_counter: NDIG-digit packed-BCD up/down counter driven by debounced
// buttons; hold-to-repeat stepping is built in when BCD_AUTOREPEAT_EN is defined.
`default_nettype none

module bcd_step_counter
  import bcd_pkg::*;
#(
  parameter int NDIG          = 4,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  wire               clk,
  input  wire               rst_ext,
  bcd_step_counter_if.slave bus
);

  logic              r_inc_prev;
  logic              r_dec_prev;
  logic [4*NDIG-1:0] r_bcd;
  logic              r_step;
  logic              r_wrap;

  logic              w_inc_evt;
  logic              w_dec_evt;
  logic              w_up;
  logic              w_dn;
  logic [4*NDIG-1:0] w_nxt;
  logic [NDIG:0]     w_c;

  assign w_inc_evt = bus.inc_deb & ~r_inc_prev;
  assign w_dec_evt = bus.dec_deb & ~r_dec_prev;

`ifdef BCD_AUTOREPEAT_EN
  localparam int MAX_C = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  rpt_state_t    r_state;
  rpt_state_t    w_state_nx;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nx;
  logic          r_dir_up;
  logic          w_dir_nx;
  logic          w_rpt_fire;
  logic          w_abort;

  // Leave any active state as soon as the held button drops, a second
  // button joins it, or clear is asserted.
  assign w_abort = bus.clr_deb | (bus.inc_deb & bus.dec_deb) |
                   ~(r_dir_up ? bus.inc_deb : bus.dec_deb);

  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_dir_nx   = r_dir_up;
    w_rpt_fire = 1'b0;
    case (r_state)
      IDLE: begin
        if (~bus.clr_deb & (bus.inc_deb ^ bus.dec_deb) & (w_inc_evt | w_dec_evt)) begin
          w_state_nx = HOLD;
          w_timer_nx = '0;
          w_dir_nx   = bus.inc_deb;
        end
      end
      HOLD: begin
        if (w_abort) begin
          w_state_nx = IDLE;
          w_timer_nx = '0;
        end else if (r_timer == TW'(HOLD_CYCLES - 1)) begin
          w_state_nx = REPEAT;
          w_timer_nx = '0;
          w_rpt_fire = 1'b1;
        end else begin
          w_timer_nx = r_timer + TW'(1);
        end
      end
      REPEAT: begin
        if (w_abort) begin
          w_state_nx = IDLE;
          w_timer_nx = '0;
        end else if (r_timer == TW'(REPEAT_CYCLES - 1)) begin
          w_timer_nx = '0;
          w_rpt_fire = 1'b1;
        end else begin
          w_timer_nx = r_timer + TW'(1);
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_timer_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_ext) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_dir_up <= 1'b1;
    end else begin
      r_state  <= w_state_nx;
      r_timer  <= w_timer_nx;
      r_dir_up <= w_dir_nx;
    end
  end

  assign w_up = ~bus.clr_deb & (((w_inc_evt & ~w_dec_evt)) | (w_rpt_fire &  r_dir_up));
  assign w_dn = ~bus.clr_deb & (((w_dec_evt & ~w_inc_evt)) | (w_rpt_fire & ~r_dir_up));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};

  assign w_up = ~bus.clr_deb & w_inc_evt & ~w_dec_evt;
  assign w_dn = ~bus.clr_deb & w_dec_evt & ~w_inc_evt;
`endif

  // Carry into the units digit doubles as the "step this cycle" enable.
  assign w_c[0] = w_up | w_dn;

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
    bcd_digit_updown u_digit (
      .i_digit (r_bcd[4*gi +: 4]),
      .i_up    (w_up),
      .i_dn    (w_dn),
      .i_cin   (w_c[gi]),
      .o_digit (w_nxt[4*gi +: 4]),
      .o_cout  (w_c[gi+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst_ext) begin
      r_inc_prev <= 1'b1;
      r_dec_prev <= 1'b1;
      r_bcd      <= '0;
      r_step     <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_inc_prev <= bus.inc_deb;
      r_dec_prev <= bus.dec_deb;
      if (bus.clr_deb) begin
        r_bcd  <= '0;
        r_step <= 1'b0;
        r_wrap <= 1'b0;
      end else if (w_c[0]) begin
        r_bcd  <= w_nxt;
        r_step <= 1'b1;
        r_wrap <= w_c[NDIG];
      end else begin
        r_step <= 1'b0;
        r_wrap <= 1'b0;
      end
    end
  end

  assign bus.bcd  = r_bcd;
  assign bus.step = r_step;
  assign bus.wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_bcd_step_counter.sv
// tb_bcd_step_counter: directed self-checking bench; inputs change and outputs
// are sampled 1 ns after each rising edge.
`default_nettype none

module tb_bcd_step_counter;

  logic clk;
  logic rst_ext;
  int   n_checks;
  int   n_fail;

  bcd_step_counter_if #(.NDIG(4)) bus ();

  bcd_step_counter #(
    .NDIG          (4),
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4)
  ) dut (
    .clk     (clk),
    .rst_ext (rst_ext),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press_inc();
    bus.inc_deb = 1'b1; tick();
    bus.inc_deb = 1'b0; tick();
  endtask

  task automatic press_dec();
    bus.dec_deb = 1'b1; tick();
    bus.dec_deb = 1'b0; tick();
  endtask

  task automatic do_clear();
    bus.clr_deb = 1'b1; tick();
    bus.clr_deb = 1'b0; tick();
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_ext     = 1'b1;
    bus.inc_deb = 1'b1;
    bus.dec_deb = 1'b0;
    bus.clr_deb = 1'b0;
    tick(2);
    chk("rst_bcd",  32'(bus.bcd),  32'h0000);
    chk("rst_step", 32'(bus.step), 32'h0);
    chk("rst_wrap", 32'(bus.wrap), 32'h0);

    // inc held across reset release must not step
    rst_ext = 1'b0;
    tick(3);
    chk("held_bcd",  32'(bus.bcd),  32'h0000);
    chk("held_step", 32'(bus.step), 32'h0);
    bus.inc_deb = 1'b0; tick();
    bus.inc_deb = 1'b1; tick();
    chk("repress_bcd",  32'(bus.bcd),  32'h0001);
    chk("repress_step", 32'(bus.step), 32'h1);
    bus.inc_deb = 1'b0; tick();
    chk("step_1cyc", 32'(bus.step), 32'h0);

    // 0000 -> 9999 on dec, wrap for one cycle
    do_clear();
    bus.dec_deb = 1'b1; tick();
    chk("dec_wrap_bcd",  32'(bus.bcd),  32'h9999);
    chk("dec_wrap_wrap", 32'(bus.wrap), 32'h1);
    chk("dec_wrap_step", 32'(bus.step), 32'h1);
    bus.dec_deb = 1'b0; tick();
    chk("dec_wrap_1cyc", 32'(bus.wrap), 32'h0);

    // 9999 -> 0000 on inc
    bus.inc_deb = 1'b1; tick();
    chk("inc_wrap_bcd",  32'(bus.bcd),  32'h0000);
    chk("inc_wrap_wrap", 32'(bus.wrap), 32'h1);
    bus.inc_deb = 1'b0; tick();
    chk("inc_wrap_1cyc", 32'(bus.wrap), 32'h0);
    chk("inc_wrap_stp0", 32'(bus.step), 32'h0);

    // count to 1000 through every carry chain length
    for (int i = 0; i < 1000; i++) press_inc();
    chk("count_1000", 32'(bus.bcd), 32'h1000);
    bus.dec_deb = 1'b1; tick();
    chk("dec_1000_bcd",  32'(bus.bcd),  32'h0999);
    chk("dec_1000_wrap", 32'(bus.wrap), 32'h0);
    bus.dec_deb = 1'b0; tick();
    bus.inc_deb = 1'b1; tick();
    chk("inc_0999_bcd",  32'(bus.bcd),  32'h1000);
    chk("inc_0999_step", 32'(bus.step), 32'h1);
    chk("inc_0999_wrap", 32'(bus.wrap), 32'h0);
    bus.inc_deb = 1'b0; tick();

    // simultaneous edges cancel
    do_clear();
    for (int i = 0; i < 42; i++) press_inc();
    chk("count_0042", 32'(bus.bcd), 32'h0042);
    bus.inc_deb = 1'b1;
    bus.dec_deb = 1'b1;
    tick();
    chk("both_bcd",  32'(bus.bcd),  32'h0042);
    chk("both_step", 32'(bus.step), 32'h0);
    chk("both_wrap", 32'(bus.wrap), 32'h0);
    bus.inc_deb = 1'b0;
    bus.dec_deb = 1'b0;
    tick();

    // clear beats a coincident inc edge
    bus.clr_deb = 1'b1;
    bus.inc_deb = 1'b1;
    tick();
    chk("clr_inc_bcd",  32'(bus.bcd),  32'h0000);
    chk("clr_inc_step", 32'(bus.step), 32'h0);
    bus.clr_deb = 1'b0;
    bus.inc_deb = 1'b0;
    tick(2);
    chk("clr_after", 32'(bus.bcd), 32'h0000);

    // long hold steps once (edge-only build)
    for (int i = 0; i < 5; i++) press_inc();
    chk("count_0005", 32'(bus.bcd), 32'h0005);
`ifndef BCD_AUTOREPEAT_EN
    bus.inc_deb = 1'b1;
    tick(1000);
    chk("hold1000_bcd",  32'(bus.bcd),  32'h0006);
    chk("hold1000_step", 32'(bus.step), 32'h0);
    bus.inc_deb = 1'b0; tick();
`endif

    // reset overrides a coincident edge
    rst_ext     = 1'b1;
    bus.inc_deb = 1'b1;
    tick();
    chk("rst_evt_bcd",  32'(bus.bcd),  32'h0000);
    chk("rst_evt_step", 32'(bus.step), 32'h0);
    rst_ext     = 1'b0;
    bus.inc_deb = 1'b0;
    tick();

`ifdef BCD_AUTOREPEAT_EN
    bus.inc_deb = 1'b1; tick();
    chk("rpt_press", 32'(bus.bcd), 32'h0001);
    tick(7);
    chk("rpt_hold7", 32'(bus.bcd), 32'h0001);
    tick();
    chk("rpt_first",      32'(bus.bcd),  32'h0002);
    chk("rpt_first_step", 32'(bus.step), 32'h1);
    tick(3);
    chk("rpt_gap", 32'(bus.bcd), 32'h0002);
    tick();
    chk("rpt_second", 32'(bus.bcd), 32'h0003);
    tick(4);
    chk("rpt_third", 32'(bus.bcd), 32'h0004);
    bus.inc_deb = 1'b0; tick(20);
    chk("rpt_release", 32'(bus.bcd), 32'h0004);

    bus.inc_deb = 1'b1; tick(14);
    chk("rpt_again", 32'(bus.bcd), 32'h0007);
    rst_ext = 1'b1; tick();
    chk("rpt_rst_bcd", 32'(bus.bcd), 32'h0000);
    rst_ext = 1'b0; tick(20);
    chk("rpt_rst_idle", 32'(bus.bcd), 32'h0000);
    bus.inc_deb = 1'b0; tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
